// File: rtl/ff_bank_if.sv
// Handshake/bus bundle for ff_bank: control and operand inputs plus the
// registered state, change flags, illegal-SR flag and toggle-event counter.
interface ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] chg;
  logic             sr_err;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output en, mode, a, b, load, load_val, cnt_clr,
    input  q, qn, chg, sr_err, toggle_cnt
  );

  modport slave (
    input  en, mode, a, b, load, load_val, cnt_clr,
    output q, qn, chg, sr_err, toggle_cnt
  );
endinterface

// File: rtl/ff_bank.sv
// Multi-mode (D/T/JK/SR) flip-flop bank with parallel load, per-bit change
// flags, an illegal-SR flag and a saturating toggle-event counter.
module ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic    clk,
  input logic    rst,
  ff_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] chg_r;
  logic             sr_err_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] q_next_s;
  logic             sr_conflict_s;
  logic [CNT_W:0]   cnt_sum_s;
  logic [CNT_W-1:0] cnt_sat_s;

  // Number of set bits; one extra bit of headroom detects counter overflow.
  function automatic logic [CNT_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + {{CNT_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Next-state selection: load beats mode-based update, which beats hold.
  always_comb begin
    q_next_s      = q_r;
    sr_conflict_s = 1'b0;
    if (bus.load) begin
      q_next_s = bus.load_val;
    end else if (bus.en) begin
      case (mode_t'(bus.mode))
        MODE_D:  q_next_s = bus.a;
        MODE_T:  q_next_s = q_r ^ bus.a;
        MODE_JK: q_next_s = (bus.a & ~q_r) | (~bus.b & q_r);
        MODE_SR: begin
          // S=R=1 bits fall through both masks and therefore hold.
          q_next_s      = (q_r | (bus.a & ~bus.b)) & ~(bus.b & ~bus.a);
          sr_conflict_s = |(bus.a & bus.b);
        end
        default: q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // Saturating accumulation of the change flags registered at the last edge.
  always_comb begin
    cnt_sum_s = {1'b0, cnt_r} + popcount(chg_r);
    if (cnt_sum_s[CNT_W]) begin
      cnt_sat_s = {CNT_W{1'b1}};
    end else begin
      cnt_sat_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // State, change flags, SR flag and counter update together on each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r      <= RESET_VAL;
      chg_r    <= '0;
      sr_err_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      q_r      <= q_next_s;
      chg_r    <= q_next_s ^ q_r;
      sr_err_r <= sr_conflict_s;
      cnt_r    <= bus.cnt_clr ? {CNT_W{1'b0}} : cnt_sat_s;
    end
  end

  assign bus.q          = q_r;
  assign bus.qn         = ~q_r;
  assign bus.chg        = chg_r;
  assign bus.sr_err     = sr_err_r;
  assign bus.toggle_cnt = cnt_r;

endmodule

// File: tb/tb_ff_bank.sv
// Scoreboard bench for ff_bank (WIDTH=8, CNT_W=4): directed vectors push
// hand-computed post-edge expectations; a monitor pops and compares them.
module tb_ff_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic [7:0] q;
    logic [7:0] chg;
    logic       sr_err;
    logic [3:0] cnt;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  ff_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ff_bank #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .RESET_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then queue the state expected after the next edge.
  task automatic step(input string tag, input logic r, input logic ld, input logic [7:0] lv,
                      input logic e, input logic [1:0] m, input logic [7:0] av,
                      input logic [7:0] bv, input logic clr, input logic [7:0] eq,
                      input logic [7:0] echg, input logic esr, input logic [3:0] ecnt);
    exp_t x;
    @(negedge clk);
    rst = r; bus.load = ld; bus.load_val = lv; bus.en = e; bus.mode = m;
    bus.a = av; bus.b = bv; bus.cnt_clr = clr;
    x.q = eq; x.chg = echg; x.sr_err = esr; x.cnt = ecnt; x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle, sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".q"},      {8'h00, bus.q},          {8'h00, e.q});
        check({e.tag, ".qn"},     {8'h00, bus.qn},         {8'h00, ~e.q});
        check({e.tag, ".chg"},    {8'h00, bus.chg},        {8'h00, e.chg});
        check({e.tag, ".sr_err"}, {15'h0000, bus.sr_err},  {15'h0000, e.sr_err});
        check({e.tag, ".cnt"},    {12'h000, bus.toggle_cnt}, {12'h000, e.cnt});
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; bus.load = 1'b0; bus.load_val = 8'h00; bus.en = 1'b0;
    bus.mode = 2'b00; bus.a = 8'h00; bus.b = 8'h00; bus.cnt_clr = 1'b0;

    //    tag       rst   ld    lv     en    mode   a      b      clr   q      chg    sr    cnt
    step("rst0",   1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    step("rst1",   1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    step("t0",     1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h0F, 1'b0, 4'd0);
    step("t1",     1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'h0F, 8'h00, 1'b0, 8'h00, 8'h0F, 1'b0, 4'd4);
    step("t2",     1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h0F, 1'b0, 4'd8);
    step("jk_sc",  1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'hFF, 1'b0, 4'd12);
    step("jk_tg",  1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0, 8'h0F, 8'hFF, 1'b0, 4'd15);
    step("jk_hd",  1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h00, 1'b0, 4'd15);
    step("clr0",   1'b0, 1'b0, 8'h00, 1'b0, 2'b10, 8'h00, 8'h00, 1'b1, 8'h0F, 8'h00, 1'b0, 4'd0);
    step("ld00",   1'b0, 1'b1, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h0F, 1'b0, 4'd0);
    step("sr_x",   1'b0, 1'b0, 8'h00, 1'b1, 2'b11, 8'h81, 8'h01, 1'b0, 8'h80, 8'h80, 1'b1, 4'd4);
    step("sr_off", 1'b0, 1'b0, 8'h00, 1'b0, 2'b11, 8'h81, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 4'd5);
    step("ld00b",  1'b0, 1'b1, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h80, 1'b0, 4'd5);
    step("idle",   1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 4'd6);
    step("pri_ld", 1'b0, 1'b1, 8'hA5, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'hA5, 1'b0, 4'd6);
    step("pri_rs", 1'b1, 1'b1, 8'h5A, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    step("ld_sr",  1'b0, 1'b1, 8'h3C, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'h3C, 8'h3C, 1'b0, 4'd0);
    step("sr_ok",  1'b0, 1'b0, 8'h00, 1'b1, 2'b11, 8'h03, 8'h0C, 1'b0, 8'h33, 8'h0F, 1'b0, 4'd4);
    step("d5a",    1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 8'h5A, 8'hFF, 1'b0, 8'h5A, 8'h69, 1'b0, 4'd8);
    step("sat0",   1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'hFF, 1'b0, 4'd12);
    step("clr_ff", 1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b1, 8'h5A, 8'hFF, 1'b0, 4'd0);
    step("sat1",   1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'hFF, 1'b0, 4'd8);
    step("sat2",   1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0, 4'd15);
    step("sat3",   1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0, 4'd15);
    step("rst2",   1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 8'hC3, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    step("deassr", 1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 8'hC3, 8'h00, 1'b0, 8'hC3, 8'hC3, 1'b0, 4'd0);
    step("after",  1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'hC3, 8'h00, 1'b0, 4'd4);

    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
